// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and div_unit.
// The master side drives operands and control; the slave side returns the result and status.
interface div_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                      start;
    logic                      cancel;
    logic                      signed_op;
    logic [DATA_WIDTH-1:0]     reg1_i;
    logic [DATA_WIDTH-1:0]     reg2_i;
    logic [2*DATA_WIDTH-1:0]   result_o;
    logic                      done;
    logic                      busy;

    modport master (
        output start, cancel, signed_op, reg1_i, reg2_i,
        input  result_o, done, busy
    );

    modport slave (
        input  start, cancel, signed_op, reg1_i, reg2_i,
        output result_o, done, busy
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider, signed or unsigned, result = {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes straight from IDLE without iterating.
module div_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

    localparam logic [DATA_WIDTH-1:0] One = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;
    logic [DATA_WIDTH-1:0]   div_q, div_d;
    logic                    qneg_q, qneg_d;
    logic                    rneg_q, rneg_d;
    logic [2*DATA_WIDTH-1:0] result_q, result_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic                    a_neg, b_neg, fast_zero, fit;
    logic [DATA_WIDTH:0]     rem_ext;
    logic [DATA_WIDTH-1:0]   rem_sub, quo_res, rem_res;

    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] x);
        return ~x + One;
    endfunction

    assign a_neg = bus.signed_op & bus.reg1_i[DATA_WIDTH-1];
    assign b_neg = bus.signed_op & bus.reg2_i[DATA_WIDTH-1];

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = (bus.reg2_i == '0);
`else
    assign fast_zero = 1'b0;
`endif

    // Partial remainder never exceeds twice the divisor, so W-bit wraparound subtraction is exact.
    assign rem_ext = {rem_q, quo_q[DATA_WIDTH-1]};
    assign fit     = (rem_ext >= {1'b0, div_q});
    assign rem_sub = rem_ext[DATA_WIDTH-1:0] - div_q;

    // Zero divisor leaves the dividend magnitude in rem; only the quotient needs forcing.
    always_comb begin
        quo_res = qneg_q ? negate(quo_q) : quo_q;
        if (div_q == '0) quo_res = '1;
        rem_res = rneg_q ? negate(rem_q) : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        done_d   = done_q;
        busy_d   = busy_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (fast_zero) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        result_d = {bus.reg1_i, {DATA_WIDTH{1'b1}}};
                    end else begin
                        state_d = StCalc;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = a_neg ? negate(bus.reg1_i) : bus.reg1_i;
                        div_d   = b_neg ? negate(bus.reg2_i) : bus.reg2_i;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                    end
                end
            end
            StCalc: begin
                rem_d = fit ? rem_sub : rem_ext[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], fit};
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) state_d = StSign;
            end
            StSign: begin
                result_d = {rem_res, quo_res};
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StDone;
            end
            StDone: begin
                if (!bus.start) begin
                    state_d  = StIdle;
                    done_d   = 1'b0;
                    result_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.cancel) begin
            state_d  = StIdle;
            cnt_d    = '0;
            done_d   = 1'b0;
            busy_d   = 1'b0;
            result_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit (W=32): expected results queued at launch, checked at done.
module tb_div_unit;
    localparam int LatFull = 34;
`ifdef DIV_ZERO_FAST_EN
    localparam int LatZero = 1;
`else
    localparam int LatZero = 34;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_v;
    logic [63:0] held;
    int          lat;
    int          busy_bad;

    div_unit_if #(.DATA_WIDTH(32)) bus ();

    div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: language division with the two defined corner cases handled explicitly.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Launch at cycle 0, scramble inputs from cycle 1, wait for done, check, then release.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat);
        sb_q.push_back(model(s, a, b));
        bus.start = 1'b1; bus.signed_op = s; bus.reg1_i = a; bus.reg2_i = b;
        lat = 0;
        busy_bad = 0;
        do begin
            step();
            lat++;
            if (lat == 1) begin
                bus.start = 1'b0; bus.signed_op = ~s;
                bus.reg1_i = $urandom; bus.reg2_i = $urandom;
            end
            if (!bus.done && !bus.busy) busy_bad++;
        end while (!bus.done && lat < 100);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        check({tag, "_busy_done"}, {63'd0, bus.busy}, 64'd0);
        exp_v = sb_q.pop_front();
        check({tag, "_result"}, bus.result_o, exp_v);
        step();
        check({tag, "_done_fall"}, {63'd0, bus.done}, 64'd0);
        check({tag, "_result_clr"}, bus.result_o, 64'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.cancel = 1'b0; bus.signed_op = 1'b0;
        bus.reg1_i = '0; bus.reg2_i = '0;
        repeat (3) step();
        check("reset_out", {bus.result_o[61:0], bus.done, bus.busy}, 64'd0);
        rst = 1'b0;
        step();

        run_op("u100_7", 1'b0, 32'd100, 32'd7, LatFull);
        run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, LatFull);
        run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, LatFull);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, LatFull);
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, LatFull);
        run_op("u_div0", 1'b0, 32'h1234, 32'd0, LatZero);
        run_op("s_div0_neg", 1'b1, 32'hFFFF_FF00, 32'd0, LatZero);
        run_op("u_big", 1'b0, 32'hDEAD_BEEF, 32'h0001_2345, LatFull);

        // Cancel mid-CALC at cycle 10.
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.reg1_i = 32'd100; bus.reg2_i = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        check("cancel_busy_before", {63'd0, bus.busy}, 64'd1);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        check("cancel_out", {bus.result_o[61:0], bus.done, bus.busy}, 64'd0);
        repeat (3) step();
        check("cancel_stays_idle", {63'd0, bus.busy | bus.done}, 64'd0);
        run_op("u9_3_after_cancel", 1'b0, 32'd9, 32'd3, LatFull);

        // start and cancel together in IDLE.
        bus.start = 1'b1; bus.cancel = 1'b1; bus.reg1_i = 32'd50; bus.reg2_i = 32'd5;
        step();
        check("start_cancel_idle", {62'd0, bus.busy, bus.done}, 64'd0);
        bus.start = 1'b0; bus.cancel = 1'b0;
        step();
        check("start_cancel_still_idle", {62'd0, bus.busy, bus.done}, 64'd0);

        // Hold start past done: result held, done stays high.
        sb_q.push_back(model(1'b0, 32'd100, 32'd7));
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.reg1_i = 32'd100; bus.reg2_i = 32'd7;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!bus.done && lat < 100);
        check("hold_lat", 64'(lat), 64'(LatFull));
        exp_v = sb_q.pop_front();
        check("hold_result", bus.result_o, exp_v);
        held = exp_v;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_stable", {bus.result_o}, held);
            check("hold_done", {63'd0, bus.done}, 64'd1);
        end
        bus.start = 1'b0;
        step();
        check("hold_drop_done", {63'd0, bus.done}, 64'd0);

        // Synchronous reset at cycle 20 mid-operation.
        bus.start = 1'b1; bus.reg1_i = 32'd1000; bus.reg2_i = 32'd3;
        step();
        bus.start = 1'b0;
        repeat (19) step();
        rst = 1'b1;
        step();
        check("rst_out", {bus.result_o[61:0], bus.done, bus.busy}, 64'd0);
        rst = 1'b0;
        step();
        check("rst_idle", {62'd0, bus.busy, bus.done}, 64'd0);
        run_op("s_after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, LatFull);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
